// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control_unit
// Brief   : Moore control FSM for a multicycle MIPS-style datapath. Define
//           MCU_BNE_EN to add the BNE instruction.
// Rev     : 1.0  initial release
// ============================================================================
module multicycle_control_unit #(
  parameter int ALU_CTRL_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero_flag,
  input  logic                  mem_ready,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  reg_write,
  output logic                  reg_dest,
  output logic                  mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            pc_src,
  output logic                  pc_en,
  output logic                  illegal_op,
  output logic [CNT_W-1:0]      instr_count,
  output logic [3:0]            state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BEQ    = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
`ifdef MCU_BNE_EN
  localparam logic [3:0] S_BNE    = 4'd12;
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  logic [3:0]       state_q, state_d;
  logic             is_sw_q, is_sw_d;
  logic             illegal_op_q, illegal_op_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             retire;
  logic             pc_write;
  logic             branch;
  logic             branchn;
  logic [2:0]       alu_op;

  function automatic logic [2:0] funct_to_alu(input logic [5:0] f);
    case (f)
      6'b100000: return ALU_ADD;
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  // State register and the bookkeeping flops that ride along with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      is_sw_q       <= 1'b0;
      illegal_op_q  <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      is_sw_q       <= is_sw_d;
      illegal_op_q  <= illegal_op_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    is_sw_d      = is_sw_q;
    illegal_op_d = illegal_op_q;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        // MEMADR needs to know load vs store after opcode may have moved on
        is_sw_d = (opcode == OP_SW);
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef MCU_BNE_EN
          OP_BNE:       state_d = S_BNE;
`endif
          default: begin
            state_d      = S_FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase

    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP, S_MEMWR: retire = 1'b1;
`ifdef MCU_BNE_EN
        S_BNE: retire = 1'b1;
`endif
        default: retire = 1'b0;
      endcase
    end
    instr_count_d = retire ? instr_count_q + 1'b1 : instr_count_q;
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dest   = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    branchn    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // Reset gating keeps the IR and PC frozen while the state is forced here
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready & rst_n;
        pc_write  = mem_ready & rst_n;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = funct_to_alu(funct);
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dest  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
`ifdef MCU_BNE_EN
      S_BNE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        branchn   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(alu_op);
  assign pc_en       = rst_n & (pc_write | (branch & zero_flag) | (branchn & ~zero_flag));
  assign state       = state_q;
  assign illegal_op  = illegal_op_q;
  assign instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_control_unit
// Brief   : Scoreboard bench for multicycle_control_unit (MCU_BNE_EN aware).
// Rev     : 1.0  initial release
// ============================================================================
module tb_multicycle_control_unit;

  localparam int ALU_CTRL_W = 4;
  localparam int CNT_W      = 4;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic                  zero_flag;
  logic                  mem_ready;
  logic                  mem_read, mem_write, iord, ir_write;
  logic                  reg_write, reg_dest, mem_to_reg, alu_src_a;
  logic [1:0]            alu_src_b;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [1:0]            pc_src;
  logic                  pc_en;
  logic                  illegal_op;
  logic [CNT_W-1:0]      instr_count;
  logic [3:0]            state;

  multicycle_control_unit #(.ALU_CTRL_W(ALU_CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dest(reg_dest), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .pc_src(pc_src), .pc_en(pc_en), .illegal_op(illegal_op),
    .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [25:0]      sb[$];
  logic             exp_ill;
  logic [CNT_W-1:0] exp_cnt;

  task automatic check_eq(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // {mem_read,mem_write,iord,ir_write,reg_write,reg_dest,mem_to_reg,alu_src_a,
  //  alu_src_b[1:0],alu[2:0],pc_src[1:0],pc_en}
  function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr,
                                          input logic zf, input logic [5:0] fn);
    case (st)
      4'd0:       return {1'b1, 2'b00, mr, 4'b0000, 2'b01, 3'b010, 2'b00, mr};
      4'd1:       return {8'h00, 2'b11, 3'b010, 3'b000};
      4'd2, 4'd9: return {8'b0000_0001, 2'b10, 3'b010, 3'b000};
      4'd3:       return {8'b1010_0000, 8'h00};
      4'd4:       return {8'b0000_1010, 8'h00};
      4'd5:       return {8'b0110_0000, 8'h00};
      4'd6:       return {8'b0000_0001, 2'b00, alu_of(fn), 3'b000};
      4'd7:       return {8'b0000_1100, 8'h00};
      4'd8:       return {8'b0000_0001, 2'b00, 3'b110, 2'b01, zf};
      4'd10:      return {8'b0000_1000, 8'h00};
      4'd11:      return {8'h00, 2'b00, 3'b000, 2'b10, 1'b1};
      4'd12:      return {8'b0000_0001, 2'b00, 3'b110, 2'b01, ~zf};
      default:    return 16'h0000;
    endcase
  endfunction

  function automatic logic [25:0] pack(input logic [3:0] st, input logic [15:0] c,
                                       input logic ill, input logic [CNT_W-1:0] cnt);
    return {st, c[15:6], 1'b0, c[5:0], ill, cnt};
  endfunction

  function automatic logic [25:0] observed();
    return {state, mem_read, mem_write, iord, ir_write, reg_write, reg_dest,
            mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src, pc_en,
            illegal_op, instr_count};
  endfunction

  // One clock cycle: drive, queue the expectation, compare mid-cycle
  task automatic cyc(input logic [3:0] st, input logic mr, input string tag);
    mem_ready = mr;
    sb.push_back(pack(st, exp_ctl(st, mr, zero_flag, funct), exp_ill, exp_cnt));
    @(negedge clk);
    check_eq(tag, observed(), sb.pop_front());
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                     input int fetch_wait, input int mem_wait, input string tag);
    opcode    = op;
    funct     = fn;
    zero_flag = zf;
    repeat (fetch_wait) cyc(4'd0, 1'b0, tag);
    cyc(4'd0, 1'b1, tag);
    cyc(4'd1, rnd(), tag);
    case (op)
      OP_LW: begin
        cyc(4'd2, rnd(), tag);
        repeat (mem_wait) cyc(4'd3, 1'b0, tag);
        cyc(4'd3, 1'b1, tag);
        cyc(4'd4, rnd(), tag);
        exp_cnt++;
      end
      OP_SW: begin
        cyc(4'd2, rnd(), tag);
        repeat (mem_wait) cyc(4'd5, 1'b0, tag);
        cyc(4'd5, 1'b1, tag);
        exp_cnt++;
      end
      OP_R: begin
        cyc(4'd6, rnd(), tag);
        cyc(4'd7, rnd(), tag);
        exp_cnt++;
      end
      OP_BEQ: begin
        cyc(4'd8, rnd(), tag);
        exp_cnt++;
      end
      OP_ADDI: begin
        cyc(4'd9, rnd(), tag);
        cyc(4'd10, rnd(), tag);
        exp_cnt++;
      end
      OP_J: begin
        cyc(4'd11, rnd(), tag);
        exp_cnt++;
      end
`ifdef MCU_BNE_EN
      OP_BNE: begin
        cyc(4'd12, rnd(), tag);
        exp_cnt++;
      end
`endif
      default: exp_ill = 1'b1;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] ops[6];
    logic [5:0] fns[6];
    ops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011111};
    exp_ill   = 1'b0;
    exp_cnt   = '0;
    rst_n     = 1'b0;
    opcode    = OP_LW;
    funct     = 6'd0;
    zero_flag = 1'b0;
    mem_ready = 1'b1;

    // Held in reset with mem_ready high: FETCH values, IR/PC writes suppressed
    repeat (2) @(posedge clk);
    sb.push_back(pack(4'd0, exp_ctl(4'd0, 1'b0, 1'b0, 6'd0), 1'b0, '0));
    @(negedge clk);
    check_eq("reset", observed(), sb.pop_front());
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run(OP_LW,   6'd0,      1'b0, 0, 0, "lw");
    run(OP_SW,   6'd0,      1'b0, 2, 3, "sw_wait");
    run(OP_R,    6'b101010, 1'b0, 0, 0, "r_slt");
    for (int i = 0; i < 6; i++) run(OP_R, fns[i], rnd(), 0, 0, "r_funct");
    run(OP_BEQ,  6'd0,      1'b1, 0, 0, "beq_taken");
    run(OP_BEQ,  6'd0,      1'b0, 0, 0, "beq_not");
    run(OP_ADDI, 6'd0,      1'b0, 1, 0, "addi");
    run(OP_J,    6'd0,      1'b0, 0, 0, "jump");
    run(6'b111111, 6'd0,    1'b0, 0, 0, "illegal");
    run(OP_LW,   6'd0,      1'b0, 0, 2, "lw_after_ill");
    run(6'b010001, 6'd0,    1'b0, 0, 0, "illegal_again");
    run(OP_BNE,  6'd0,      1'b0, 0, 0, "bne_nz");
    run(OP_BNE,  6'd0,      1'b1, 0, 0, "bne_z");
    for (int i = 0; i < 20; i++)
      run(ops[$urandom_range(0, 5)], fns[$urandom_range(0, 5)], rnd(),
          $urandom_range(0, 2), $urandom_range(0, 2), "random");

    // Reset pulsed while a load waits in MEMRD
    opcode = OP_LW;
    cyc(4'd0, 1'b1, "lw_abort");
    cyc(4'd1, 1'b1, "lw_abort");
    cyc(4'd2, 1'b1, "lw_abort");
    cyc(4'd3, 1'b0, "lw_abort");
    mem_ready = 1'b1;
    #2;
    rst_n   = 1'b0;
    exp_ill = 1'b0;
    exp_cnt = '0;
    #1;
    sb.push_back(pack(4'd0, exp_ctl(4'd0, 1'b0, 1'b0, 6'd0), 1'b0, '0));
    check_eq("async_reset", observed(), sb.pop_front());
    @(posedge clk);
    #1;
    sb.push_back(pack(4'd0, exp_ctl(4'd0, 1'b0, 1'b0, 6'd0), 1'b0, '0));
    check_eq("reset_hold", observed(), sb.pop_front());
    rst_n = 1'b1;
    run(OP_LW, 6'd0, 1'b0, 0, 0, "lw_after_reset");
    run(OP_SW, 6'd0, 1'b0, 0, 1, "sw_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
